// File: rtl/obuf_arb_ctrl_pkg.sv
// Shared mesh-node definitions: direction indices, port count, default payload width and
// the round-robin index helper used by the output arbiters.
package obuf_arb_ctrl_pkg;

    localparam int unsigned NUM_DIR    = 5;
    localparam int unsigned DIR_N      = 0;
    localparam int unsigned DIR_W      = 1;
    localparam int unsigned DIR_S      = 2;
    localparam int unsigned DIR_E      = 3;
    localparam int unsigned DIR_B      = 4;
    localparam int unsigned PYLD_W_DEF = 23;

    typedef logic [2:0] dir_idx_t;

    // Last-granted value after reset, so N is searched first.
    localparam dir_idx_t RR_RESET = dir_idx_t'(DIR_B);

    // (base + off) mod NUM_DIR for base in 0..4 and off in 0..5.
    function automatic dir_idx_t dir_add(input dir_idx_t base, input dir_idx_t off);
        logic [3:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= 4'(NUM_DIR)) begin
            sum = sum - 4'(NUM_DIR);
        end
        return sum[2:0];
    endfunction

endpackage

// File: rtl/obuf_arb_ctrl_rr_arb5.sv
// Combinational five-way round-robin arbiter: the first requester after ptr (with wrap)
// receives the one-hot grant; en low forces no grant.
module obuf_arb_ctrl_rr_arb5
    import obuf_arb_ctrl_pkg::*;
(
    input  logic [NUM_DIR-1:0] req,
    input  dir_idx_t           ptr,
    input  logic               en,
    output logic [NUM_DIR-1:0] gnt,
    output dir_idx_t           gnt_idx
);

    dir_idx_t cand;
    logic     found;

    always_comb begin
        gnt     = '0;
        gnt_idx = ptr;
        cand    = '0;
        found   = 1'b0;
        // Offsets 1..5 visit every source once, ending at ptr itself.
        for (int k = 1; k <= int'(NUM_DIR); k++) begin
            cand = dir_add(ptr, dir_idx_t'(k));
            if (en && !found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = cand;
            end
        end
    end

endmodule

// File: rtl/obuf_arb_ctrl.sv
// Output-port controller: round-robin grant over the five input buffers, capture of the
// granted payload into a 2-entry FIFO, and valid/ready drain to the outgoing link.
module obuf_arb_ctrl
    import obuf_arb_ctrl_pkg::*;
#(
    parameter int unsigned PYLD_W = PYLD_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pg_en,
    input  logic [NUM_DIR-1:0]        arb_req,
    input  logic [NUM_DIR*PYLD_W-1:0] payload_i,
    output logic [NUM_DIR-1:0]        arb_gnt,
    output logic                      obuf_rdy,
    output logic                      link_vld,
    input  logic                      link_rdy,
    output logic [PYLD_W-1:0]         link_payload
);

    dir_idx_t          rr_ptr_q;
    dir_idx_t          gnt_idx;
    logic              accept;
    logic              pop;
    logic [PYLD_W-1:0] push_data;

    logic [PYLD_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;
    logic [1:0]        count_d;

    obuf_arb_ctrl_rr_arb5 u_rr_arb5 (
        .req     (arb_req),
        .ptr     (rr_ptr_q),
        .en      (~pg_en),
        .gnt     (arb_gnt),
        .gnt_idx (gnt_idx)
    );

    assign obuf_rdy = ~pg_en & (count_q != 2'd2);
    // Same condition the input buffer uses to drop its request.
    assign accept   = obuf_rdy & (|(arb_req & arb_gnt));
    assign link_vld = (count_q != 2'd0);
    assign pop      = link_vld & link_rdy;
    assign link_payload = mem_q[rd_ptr_q];

    // One-hot grant select keeps payload_i off every output-facing combinational path.
    always_comb begin
        push_data = '0;
        for (int i = 0; i < int'(NUM_DIR); i++) begin
            if (arb_gnt[i]) begin
                push_data = push_data | payload_i[i*PYLD_W +: PYLD_W];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= RR_RESET;
        end else if (accept) begin
            rr_ptr_q <= gnt_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

`ifndef SYNTHESIS
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(arb_gnt));
    a_count_max  : assert property (@(posedge clk) disable iff (!rst_n) count_q <= 2'd2);
    a_no_ovf     : assert property (@(posedge clk) disable iff (!rst_n)
                                    !(accept && count_q == 2'd2));
    a_ptr_range  : assert property (@(posedge clk) disable iff (!rst_n)
                                    rr_ptr_q < dir_idx_t'(NUM_DIR));
`endif

endmodule

// File: tb/tb_obuf_arb_ctrl.sv
// Self-checking bench for obuf_arb_ctrl: directed scenarios plus a randomized run, all
// against a queue-based round-robin reference model.
module tb_obuf_arb_ctrl;

    localparam int PW = 23;
    localparam int ND = 5;

    logic              clk;
    logic              rst_n;
    logic              pg_en;
    logic [ND-1:0]     arb_req;
    logic [ND*PW-1:0]  payload_i;
    logic [ND-1:0]     arb_gnt;
    logic              obuf_rdy;
    logic              link_vld;
    logic              link_rdy;
    logic [PW-1:0]     link_payload;

    int n_checks;
    int n_errors;

    int            m_rr;
    logic [PW-1:0] m_q [$];

    obuf_arb_ctrl #(.PYLD_W(PW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pg_en        (pg_en),
        .arb_req      (arb_req),
        .payload_i    (payload_i),
        .arb_gnt      (arb_gnt),
        .obuf_rdy     (obuf_rdy),
        .link_vld     (link_vld),
        .link_rdy     (link_rdy),
        .link_payload (link_payload)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [ND-1:0] model_gnt(input logic [ND-1:0] req, input logic pg);
        logic [ND-1:0] g;
        g = '0;
        if (!pg) begin
            for (int k = 1; k <= ND; k++) begin
                int i;
                i = (m_rr + k) % ND;
                if (req[i] && g == '0) g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic void step_model();
        logic [ND-1:0] g;
        logic          acc;
        logic          pp;
        g   = model_gnt(arb_req, pg_en);
        acc = (g != '0) && (m_q.size() < 2);
        pp  = (m_q.size() != 0) && link_rdy;
        if (pp) void'(m_q.pop_front());
        if (acc) begin
            for (int i = 0; i < ND; i++) begin
                if (g[i]) begin
                    m_q.push_back(payload_i[i*PW +: PW]);
                    m_rr = i;
                end
            end
        end
    endfunction

    // Called on a falling edge; leaves time at falling edge + 1.
    task automatic drive(input logic [ND-1:0] req, input logic pg, input logic rdy);
        arb_req  = req;
        pg_en    = pg;
        link_rdy = rdy;
        for (int i = 0; i < ND; i++) payload_i[i*PW +: PW] = PW'($urandom);
        #1;
    endtask

    task automatic advance();
        step_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        arb_req  = '0;
        pg_en    = 1'b0;
        link_rdy = 1'b0;
        payload_i = '0;
        m_rr = 4;
        m_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(5'b00000, 1'b0, 1'b1);
        n_checks++;
        if (arb_gnt !== 5'b00000) begin
            n_errors++; $display("FAIL reset_gnt: got %b expected 00000", arb_gnt);
        end
        n_checks++;
        if (obuf_rdy !== 1'b1) begin
            n_errors++; $display("FAIL reset_rdy: got %b expected 1", obuf_rdy);
        end
        n_checks++;
        if (link_vld !== 1'b0 || link_payload !== '0) begin
            n_errors++; $display("FAIL reset_link: got vld=%b pay=%h expected vld=0 pay=0",
                                 link_vld, link_payload);
        end
    endtask

    task automatic test_single();
        logic [PW-1:0] p;
        do_reset();
        drive(5'b00001, 1'b0, 1'b1);
        p = payload_i[0 +: PW];
        n_checks++;
        if (arb_gnt !== 5'b00001 || obuf_rdy !== 1'b1) begin
            n_errors++; $display("FAIL single_gnt: got gnt=%b rdy=%b expected gnt=00001 rdy=1",
                                 arb_gnt, obuf_rdy);
        end
        advance();
        drive(5'b00000, 1'b0, 1'b0);
        n_checks++;
        if (link_vld !== 1'b1 || link_payload !== p) begin
            n_errors++; $display("FAIL single_link: got vld=%b pay=%h expected vld=1 pay=%h",
                                 link_vld, link_payload, p);
        end
        n_checks++;
        if (dut.rr_ptr_q !== 3'd0) begin
            n_errors++; $display("FAIL single_rrptr: got %0d expected 0", dut.rr_ptr_q);
        end
    endtask

    task automatic test_rotation();
        int            seq [6] = '{0, 1, 2, 3, 4, 0};
        logic [PW-1:0] prev;
        logic [ND-1:0] exp_g;
        do_reset();
        prev = '0;
        for (int c = 0; c < 6; c++) begin
            drive(5'b11111, 1'b0, 1'b1);
            exp_g = '0;
            exp_g[seq[c]] = 1'b1;
            n_checks++;
            if (arb_gnt !== exp_g) begin
                n_errors++; $display("FAIL rotation_gnt[%0d]: got %b expected %b",
                                     c, arb_gnt, exp_g);
            end
            if (c > 0) begin
                n_checks++;
                if (link_vld !== 1'b1 || link_payload !== prev) begin
                    n_errors++; $display("FAIL rotation_link[%0d]: got vld=%b pay=%h expected 1 %h",
                                         c, link_vld, link_payload, prev);
                end
            end
            prev = payload_i[seq[c]*PW +: PW];
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] p0;
        logic [PW-1:0] p1;
        do_reset();
        drive(5'b11111, 1'b0, 1'b0);
        p0 = payload_i[0 +: PW];
        advance();
        drive(5'b11111, 1'b0, 1'b0);
        p1 = payload_i[PW +: PW];
        advance();
        drive(5'b11111, 1'b0, 1'b0);
        n_checks++;
        if (dut.count_q !== 2'd2 || obuf_rdy !== 1'b0 || arb_gnt !== 5'b00100) begin
            n_errors++; $display("FAIL bp_full: got cnt=%0d rdy=%b gnt=%b expected 2 0 00100",
                                 dut.count_q, obuf_rdy, arb_gnt);
        end
        advance();
        drive(5'b11111, 1'b0, 1'b1);
        n_checks++;
        if (obuf_rdy !== 1'b0 || link_payload !== p0) begin
            n_errors++; $display("FAIL bp_pop_cycle: got rdy=%b pay=%h expected 0 %h",
                                 obuf_rdy, link_payload, p0);
        end
        arb_req = 5'b00000;
        #1;
        advance();
        drive(5'b00000, 1'b0, 1'b0);
        n_checks++;
        if (obuf_rdy !== 1'b1 || link_payload !== p1 || dut.count_q !== 2'd1) begin
            n_errors++; $display("FAIL bp_after_pop: got rdy=%b pay=%h cnt=%0d expected 1 %h 1",
                                 obuf_rdy, link_payload, dut.count_q, p1);
        end
    endtask

    task automatic test_push_pop();
        logic [PW-1:0] pa;
        logic [PW-1:0] pb;
        do_reset();
        drive(5'b00010, 1'b0, 1'b0);
        pa = payload_i[PW +: PW];
        advance();
        drive(5'b01000, 1'b0, 1'b1);
        pb = payload_i[3*PW +: PW];
        n_checks++;
        if (link_payload !== pa) begin
            n_errors++; $display("FAIL pp_head: got %h expected %h", link_payload, pa);
        end
        advance();
        drive(5'b00000, 1'b0, 1'b0);
        n_checks++;
        if (dut.count_q !== 2'd1 || link_vld !== 1'b1 || link_payload !== pb) begin
            n_errors++; $display("FAIL pp_after: got cnt=%0d vld=%b pay=%h expected 1 1 %h",
                                 dut.count_q, link_vld, link_payload, pb);
        end
    endtask

    task automatic test_pg_en();
        do_reset();
        drive(5'b00001, 1'b0, 1'b0);
        advance();
        drive(5'b00010, 1'b0, 1'b0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(5'b00100, 1'b1, 1'b1);
            n_checks++;
            if (arb_gnt !== 5'b00000 || obuf_rdy !== 1'b0) begin
                n_errors++; $display("FAIL pg_block[%0d]: got gnt=%b rdy=%b expected 00000 0",
                                     c, arb_gnt, obuf_rdy);
            end
            n_checks++;
            if (link_vld !== (c < 2)) begin
                n_errors++; $display("FAIL pg_drain[%0d]: got vld=%b expected %b",
                                     c, link_vld, (c < 2));
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(5'b11111, 1'b0, 1'b0);
        advance();
        drive(5'b11111, 1'b0, 1'b0);
        advance();
        drive(5'b11111, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (link_vld !== 1'b0 || link_payload !== '0) begin
            n_errors++; $display("FAIL async_rst_link: got vld=%b pay=%h expected 0 0",
                                 link_vld, link_payload);
        end
        n_checks++;
        if (dut.rr_ptr_q !== 3'd4 || dut.count_q !== 2'd0) begin
            n_errors++; $display("FAIL async_rst_state: got rr=%0d cnt=%0d expected 4 0",
                                 dut.rr_ptr_q, dut.count_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_rr = 4;
        m_q.delete();
        drive(5'b11111, 1'b0, 1'b1);
        n_checks++;
        if (arb_gnt !== 5'b00001) begin
            n_errors++; $display("FAIL async_rst_first: got %b expected 00001", arb_gnt);
        end
        advance();
    endtask

    task automatic test_random();
        logic [ND-1:0] exp_g;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(ND'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 3) != 0));
            exp_g = model_gnt(arb_req, pg_en);
            n_checks++;
            if (arb_gnt !== exp_g) begin
                n_errors++; $display("FAIL rand_gnt[%0d]: got %b expected %b", c, arb_gnt, exp_g);
            end
            n_checks++;
            if (obuf_rdy !== (!pg_en && m_q.size() < 2)) begin
                n_errors++; $display("FAIL rand_rdy[%0d]: got %b expected %b",
                                     c, obuf_rdy, (!pg_en && m_q.size() < 2));
            end
            n_checks++;
            if (link_vld !== (m_q.size() != 0)) begin
                n_errors++; $display("FAIL rand_vld[%0d]: got %b expected %b",
                                     c, link_vld, (m_q.size() != 0));
            end
            if (m_q.size() != 0) begin
                n_checks++;
                if (link_payload !== m_q[0]) begin
                    n_errors++; $display("FAIL rand_pay[%0d]: got %h expected %h",
                                         c, link_payload, m_q[0]);
                end
            end
            advance();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        pg_en     = 1'b0;
        arb_req   = '0;
        link_rdy  = 1'b0;
        payload_i = '0;
        m_rr      = 4;
        test_reset();
        test_single();
        test_rotation();
        test_backpressure();
        test_push_pop();
        test_pg_en();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
